// File: rtl/multi_pass_accum_pkg.sv
// Shared types and width helpers for the multi-pass partial-sum accumulator.
// Width helpers are constant functions so they can size ports and parameters.
package multi_pass_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SUM   = 2'd2
   } state_t;

   function automatic int sum_w(input int acc_w, input int num_ch);
      return acc_w + $clog2(num_ch);
   endfunction

   function automatic int cnt_w(input int num_pass);
      return $clog2(num_pass + 1);
   endfunction

endpackage

// File: rtl/multi_pass_accum_acc_lane.sv
// One channel accumulator: load or add a sign-extended partial product.
// ACC_SAT_EN selects saturating adds with a per-cycle clip flag; otherwise it wraps.
module acc_lane
   import multi_pass_accum_pkg::*;
#(
   parameter int DOT_W = 21,
   parameter int ACC_W = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_add,
   input  logic [DOT_W-1:0] i_dot,
`ifdef ACC_SAT_EN
   output logic             o_clip,
`endif
   output logic [ACC_W-1:0] o_acc
);

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_dot;
   logic [ACC_W-1:0] w_nxt;

   assign w_dot = ACC_W'($signed(i_dot));

`ifdef ACC_SAT_EN
   logic [ACC_W:0] w_sum;
   logic           w_ovf;

   // One guard bit: guard and MSB disagree exactly when the signed add overflowed.
   assign w_sum  = {r_acc[ACC_W-1], r_acc} + {w_dot[ACC_W-1], w_dot};
   assign w_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
   assign w_nxt  = w_ovf ? {w_sum[ACC_W], {(ACC_W-1){~w_sum[ACC_W]}}} : w_sum[ACC_W-1:0];
   assign o_clip = i_add & w_ovf;
`else
   assign w_nxt  = r_acc + w_dot;
`endif

   always_ff @(posedge clk) begin
      if (rst)         r_acc <= '0;
      else if (i_load) r_acc <= w_dot;
      else if (i_add)  r_acc <= w_nxt;
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/multi_pass_accum.sv
// Multi-pass per-channel accumulator with cross-channel sum and compressor handshake.
// Optional feature macro: ACC_SAT_EN (saturating accumulators plus sticky acc_sat output).
module multi_pass_accum
   import multi_pass_accum_pkg::*;
#(
   parameter int NUM_CH   = 3,
   parameter int DOT_W    = 21,
   parameter int NUM_PASS = 3,
   parameter int ACC_W    = 23,
   parameter int OUT_W    = 8,
   localparam int SUM_W   = sum_w(ACC_W, NUM_CH),
   localparam int CNT_W   = cnt_w(NUM_PASS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_vld,
   output logic                    in_rdy,
   input  logic                    in_first,
   input  logic [NUM_CH*DOT_W-1:0] dot_in,
   output logic [SUM_W-1:0]        sum_all,
   output logic                    sum_vld,
   input  logic                    cmp_vld,
   input  logic [OUT_W-1:0]        compress,
   output logic [OUT_W-1:0]        ans_reg,
   output logic                    ans_vld,
`ifdef ACC_SAT_EN
   output logic                    acc_sat,
`endif
   output logic                    seq_err
);

   state_t                        r_state, w_state_nxt;
   logic [CNT_W-1:0]              r_cnt, w_cnt_nxt;
   logic [OUT_W-1:0]              r_ans;
   logic                          r_ans_vld, r_err;
   logic                          w_accept, w_load, w_add, w_err, w_take;
   logic [NUM_CH-1:0][ACC_W-1:0]  w_acc;
   logic signed [SUM_W-1:0]       w_sum;

   assign in_rdy   = (r_state != SUM);
   assign w_accept = in_vld & in_rdy;
   assign w_take   = (r_state == SUM) & cmp_vld;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_add       = 1'b0;
      w_err       = cmp_vld & (r_state != SUM);
      case (r_state)
         IDLE: if (w_accept) begin
            if (in_first) begin
               w_load      = 1'b1;
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = (NUM_PASS == 1) ? SUM : ACCUM;
            end else begin
               w_err       = 1'b1;
            end
         end
         ACCUM: if (w_accept) begin
            if (in_first) begin
               // Restart: the new first beat replaces the partial result.
               w_load      = 1'b1;
               w_err       = 1'b1;
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = (NUM_PASS == 1) ? SUM : ACCUM;
            end else begin
               w_add       = 1'b1;
               w_cnt_nxt   = r_cnt + 1'b1;
               if (r_cnt == CNT_W'(NUM_PASS - 1)) w_state_nxt = SUM;
            end
         end
         SUM: if (cmp_vld) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_ans     <= '0;
         r_ans_vld <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ans_vld <= w_take;
         r_err     <= w_err;
         if (w_take) r_ans <= compress;
      end
   end

`ifdef ACC_SAT_EN
   logic [NUM_CH-1:0] w_clip;
   logic              r_sat;

   always_ff @(posedge clk) begin
      if (rst)          r_sat <= 1'b0;
      else if (w_load)  r_sat <= 1'b0;
      else if (|w_clip) r_sat <= 1'b1;
   end
   assign acc_sat = r_sat;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      acc_lane #(.DOT_W(DOT_W), .ACC_W(ACC_W)) u_lane (
         .clk    (clk),
         .rst    (rst),
         .i_load (w_load),
         .i_add  (w_add),
         .i_dot  (dot_in[c*DOT_W +: DOT_W]),
`ifdef ACC_SAT_EN
         .o_clip (w_clip[c]),
`endif
         .o_acc  (w_acc[c])
      );
   end

   // SUM_W carries log2(NUM_CH) growth bits, so the sign-extended reduction cannot overflow.
   always_comb begin
      w_sum = '0;
      for (int c = 0; c < NUM_CH; c++) w_sum = w_sum + SUM_W'($signed(w_acc[c]));
   end

   assign sum_all = w_sum;
   assign sum_vld = (r_state == SUM);
   assign ans_reg = r_ans;
   assign ans_vld = r_ans_vld;
   assign seq_err = r_err;

endmodule
